// File: rtl/bmf_block_unpack.sv
// rtl/bmf_block_unpack.sv - block-minifloat block to per-element normalized float unpacker
// Optional BMF_UNPACK_BACK2BACK_EN: accept the next block on the last element's handshake.
module bmf_block_unpack #(
  parameter int LENGTH = 4,
  parameter int NEXP   = 4,
  parameter int NMANT  = 4,
  localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NEXP-1:0]         in_shared_exp,
  input  logic [LENGTH-1:0]       in_sign_array,
  input  logic [LENGTH*NMANT-1:0] in_mant_array,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [NEXP-1:0]         out_exp,
  output logic [NMANT-2:0]        out_frac,
  output logic [IW-1:0]           out_idx,
  output logic                    out_last,
  output logic                    out_zero,
  output logic                    out_uflow
);

  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  typedef struct packed {
    logic            sign;
    logic [NEXP-1:0] exp;
    logic [NMANT-2:0] frac;
    logic            zero;
    logic            uflow;
  } elem_t;

  // Normalize one aligned mantissa against the shared exponent; exponent 0 encodes zero.
  function automatic elem_t convert(input logic [NEXP-1:0] se, input logic [NMANT-1:0] m,
                                    input logic s);
    elem_t            e;
    int               lz;
    int               ediff;
    logic [NMANT-2:0] sh;
    e      = '0;
    e.sign = s;
    lz     = 0;
    for (int i = 0; i < NMANT; i++) begin
      if (m[i]) lz = NMANT - 1 - i;
    end
    sh    = m[NMANT-2:0] << lz;
    ediff = int'(se) - lz;
    if (m == '0) begin
      e.zero = 1'b1;
    end else if (ediff > 0) begin
      e.exp  = NEXP'(ediff);
      e.frac = sh;
    end else begin
      e.zero  = 1'b1;
      e.uflow = 1'b1;
    end
    return e;
  endfunction

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_out_hs;
  logic [NEXP-1:0]           r_exp;
  logic [LENGTH-1:0]         r_sign;
  logic [LENGTH*NMANT-1:0]   r_mant;
  elem_t                     r_elem;
  logic [IW-1:0]             r_idx;
  logic                      r_last;
  logic [IW-1:0]             w_nidx;
  elem_t                     w_first;
  elem_t                     w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        w_out_hs = out_ready;
        if (out_ready && r_last) begin
          w_state_nxt = S_IDLE;
`ifdef BMF_UNPACK_BACK2BACK_EN
          in_ready = 1'b1;
          if (in_valid) w_state_nxt = S_EMIT;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_accept = in_valid && in_ready;
  end

  // Element 0 comes straight from the accepted block; later elements from the stored copy.
  assign w_nidx  = r_last ? '0 : r_idx + 1'b1;
  assign w_first = convert(in_shared_exp, in_mant_array[NMANT-1:0], in_sign_array[0]);
  assign w_next  = convert(r_exp, r_mant[w_nidx*NMANT +: NMANT], r_sign[w_nidx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp  <= '0;
      r_sign <= '0;
      r_mant <= '0;
      r_elem <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_exp  <= in_shared_exp;
      r_sign <= in_sign_array;
      r_mant <= in_mant_array;
      r_elem <= w_first;
      r_idx  <= '0;
      r_last <= (LENGTH == 1);
    end else if (w_out_hs && !r_last) begin
      r_elem <= w_next;
      r_idx  <= w_nidx;
      r_last <= (w_nidx == LAST_IDX);
    end
  end

  assign out_valid = (r_state == S_EMIT);
  assign out_sign  = r_elem.sign;
  assign out_exp   = r_elem.exp;
  assign out_frac  = r_elem.frac;
  assign out_zero  = r_elem.zero;
  assign out_uflow = r_elem.uflow;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

endmodule

// File: tb/tb_bmf_block_unpack.sv
// tb/tb_bmf_block_unpack.sv - self-checking bench for bmf_block_unpack (LENGTH=4, NEXP=4, NMANT=4)
module tb_bmf_block_unpack;

  localparam int L = 4;
`ifdef BMF_UNPACK_BACK2BACK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [2:0] frac;
    logic       zero;
    logic       uflow;
  } elem_t;
  typedef elem_t [3:0] blk_t;
  typedef struct packed {
    logic [3:0]  se;
    logic [3:0]  signs;
    logic [15:0] mant;
    blk_t        exp_e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_shared_exp = '0;
  logic [3:0]  in_sign_array = '0;
  logic [15:0] in_mant_array = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [3:0]  out_exp;
  logic [2:0]  out_frac;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_zero;
  logic        out_uflow;

  int errors = 0;
  int checks = 0;
  vec_t vecs [4];
  logic [13:0] mon [16];

  always #5 clk = ~clk;

  bmf_block_unpack #(.LENGTH(4), .NEXP(4), .NMANT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_shared_exp(in_shared_exp), .in_sign_array(in_sign_array), .in_mant_array(in_mant_array),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_idx(out_idx), .out_last(out_last), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic elem_t mk(input bit s, input int e, input int f, input bit z, input bit u);
    elem_t r;
    r.sign  = s;
    r.exp   = 4'(e);
    r.frac  = 3'(f);
    r.zero  = z;
    r.uflow = u;
    return r;
  endfunction

  // Reference: scale m by 2 until it reaches [8,15]; each doubling costs one exponent step.
  function automatic elem_t ref_elem(input int se, input int m, input bit s);
    elem_t e;
    int v;
    int k;
    e = '0;
    e.sign = s;
    if (m == 0) begin
      e.zero = 1'b1;
      return e;
    end
    v = m;
    k = 0;
    while (v < 8) begin
      v = v * 2;
      k++;
    end
    if (se - k >= 1) begin
      e.exp  = 4'(se - k);
      e.frac = 3'(v - 8);
    end else begin
      e.zero  = 1'b1;
      e.uflow = 1'b1;
    end
    return e;
  endfunction

  function automatic blk_t ref_block(input logic [3:0] se, input logic [3:0] sg, input logic [15:0] m);
    blk_t r;
    for (int i = 0; i < L; i++) r[i] = ref_elem(int'(se), int'(m[i*4 +: 4]), sg[i]);
    return r;
  endfunction

  function automatic logic [13:0] snap();
    return {out_valid, out_idx, out_last, out_sign, out_exp, out_frac, out_zero, out_uflow};
  endfunction

  function automatic logic [13:0] exp_snap(input int i, input elem_t e);
    return {1'b1, 2'(i), (i == L - 1), e};
  endfunction

  task automatic set_block(input vec_t v);
    in_shared_exp = v.se;
    in_sign_array = v.signs;
    in_mant_array = v.mant;
  endtask

  task automatic send_block(input logic [3:0] se, input logic [3:0] sg, input logic [15:0] m,
                            input string tag);
    int n;
    n = 0;
    in_valid      = 1'b1;
    in_shared_exp = se;
    in_sign_array = sg;
    in_mant_array = m;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv_block(input blk_t e, input bit rnd, input string tag, output int lat);
    int i;
    int n;
    bit held;
    logic [13:0] prev;
    i = 0;
    n = 0;
    held = 1'b0;
    prev = '0;
    lat = -1;
    while (i < L && n < 200) begin
      @(negedge clk);
      if (held) chk({tag, "_hold"}, 32'(snap()), 32'(prev));
      held = out_valid && !out_ready;
      prev = snap();
      if (out_valid && out_ready) begin
        if (lat < 0) lat = n;
        chk($sformatf("%s_e%0d", tag, i), 32'(snap()), 32'(exp_snap(i, e[i])));
        i++;
      end
      n++;
      @(posedge clk);
      #1 out_ready = (rnd && i < L) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (i < L) chk({tag, "_timeout"}, 32'(i), 32'(L));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [13:0] hold_v;
    logic [3:0] se;
    logic [3:0] sg;
    logic [15:0] m;
    int pos [$];

    vecs[0] = {4'd8, 4'b0100, {4'b0001, 4'b0000, 4'b0110, 4'b1000},
               mk(0, 5, 0, 0, 0), mk(1, 0, 0, 1, 0), mk(0, 7, 4, 0, 0), mk(0, 8, 0, 0, 0)};
    vecs[1] = {4'd2, 4'b0000, {4'b1000, 4'b0100, 4'b0010, 4'b0001},
               mk(0, 2, 0, 0, 0), mk(0, 1, 0, 0, 0), mk(0, 0, 0, 1, 1), mk(0, 0, 0, 1, 1)};
    vecs[2] = {4'd15, 4'b1011, {4'b1010, 4'b0011, 4'b0101, 4'b1111},
               mk(1, 15, 2, 0, 0), mk(0, 13, 4, 0, 0), mk(1, 14, 2, 0, 0), mk(1, 15, 7, 0, 0)};
    vecs[3] = {4'd0, 4'b0001, {4'b0001, 4'b0111, 4'b0000, 4'b1000},
               mk(0, 0, 0, 1, 1), mk(0, 0, 0, 1, 1), mk(0, 0, 0, 1, 0), mk(1, 0, 0, 1, 1)};

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(snap()), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) begin
      send_block(vecs[t].se, vecs[t].signs, vecs[t].mant, $sformatf("vec%0d", t));
      recv_block(vecs[t].exp_e, 1'b0, $sformatf("vec%0d", t), lat);
      chk($sformatf("vec%0d_latency", t), 32'(lat), 32'd0);
    end

    // Backpressure: three stalled cycles on element 1.
    send_block(vecs[0].se, vecs[0].signs, vecs[0].mant, "bp");
    @(negedge clk);
    chk("bp_e0", 32'(snap()), 32'(exp_snap(0, vecs[0].exp_e[0])));
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    hold_v = snap();
    chk("bp_e1", 32'(hold_v), 32'(exp_snap(1, vecs[0].exp_e[1])));
    repeat (2) begin
      @(negedge clk);
      chk("bp_stable", 32'(snap()), 32'(hold_v));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_e1", 32'(snap()), 32'(exp_snap(1, vecs[0].exp_e[1])));
    @(negedge clk);
    chk("bp_e2", 32'(snap()), 32'(exp_snap(2, vecs[0].exp_e[2])));
    @(negedge clk);
    chk("bp_e3", 32'(snap()), 32'(exp_snap(3, vecs[0].exp_e[3])));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_done", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Input pulse mid-block must be ignored.
    send_block(vecs[2].se, vecs[2].signs, vecs[2].mant, "stall");
    @(negedge clk);
    chk("stall_e0", 32'(snap()), 32'(exp_snap(0, vecs[2].exp_e[0])));
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    set_block(vecs[3]);
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_e1", 32'(snap()), 32'(exp_snap(1, vecs[2].exp_e[1])));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall_e2", 32'(snap()), 32'(exp_snap(2, vecs[2].exp_e[2])));
    @(negedge clk);
    chk("stall_e3", 32'(snap()), 32'(exp_snap(3, vecs[2].exp_e[3])));
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_no_accept", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Back-to-back: in_valid held across two blocks.
    fork
      begin
        n = 0;
        in_valid = 1'b1;
        set_block(vecs[1]);
        do begin
          @(negedge clk);
          n++;
        end while (!in_ready && n < 50);
        @(posedge clk);
        #1 set_block(vecs[2]);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!in_ready && n < 50);
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          mon[c] = snap();
        end
      end
    join
    pos.delete();
    for (int c = 0; c < 16; c++) if (mon[c][13]) pos.push_back(c);
    chk("b2b_count", 32'(pos.size()), 32'd8);
    for (int k = 0; k < 8 && k < pos.size(); k++)
      chk($sformatf("b2b_e%0d", k), 32'(mon[pos[k]]),
          32'(exp_snap(k % 4, (k < 4) ? vecs[1].exp_e[k % 4] : vecs[2].exp_e[k % 4])));
    if (pos.size() >= 8) begin
      chk("b2b_gap", 32'(pos[4] - pos[3] - 1), 32'(GAP));
      chk("b2b_span", 32'(pos[7] - pos[0]), 32'(7 + GAP));
    end
    @(posedge clk);
    #1;

    // Asynchronous reset during element 2.
    send_block(vecs[0].se, vecs[0].signs, vecs[0].mant, "rst");
    repeat (3) @(negedge clk);
    chk("rst_at_e2", 32'(snap()), 32'(exp_snap(2, vecs[0].exp_e[2])));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'(snap()), 32'd0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk);
    #1;
    send_block(vecs[1].se, vecs[1].signs, vecs[1].mant, "post_rst");
    recv_block(vecs[1].exp_e, 1'b0, "post_rst", lat);
    chk("post_rst_latency", 32'(lat), 32'd0);

    // Random blocks with random out_ready against the reference model.
    for (int b = 0; b < 30; b++) begin
      se = 4'($urandom_range(0, 15));
      sg = 4'($urandom);
      m  = 16'($urandom);
      for (int k = 0; k < L; k++)
        if ($urandom_range(0, 3) == 0) m[k*4 +: 4] = 4'($urandom_range(0, 1));
      send_block(se, sg, m, $sformatf("rnd%0d", b));
      recv_block(ref_block(se, sg, m), 1'b1, $sformatf("rnd%0d", b), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
